uart_rx_frame_engine: RTL and testbench
=======================================

Name: uart_rx_frame_engine

Overview:
- Parametrised UART receive framer; next generation of the fixed 5–8 bit receiver.
- Data width runs from 5 to MAX_DATA_WIDTH bits, chosen per frame. Five parity modes, including mark and space. Stop bits are 1 or 2.
- Uses majority-vote oversampling and detects break conditions.
- Sits between the RX pin and the RX FIFO. The oversample tick comes from the shared baud generator.

Parameters:
- MAX_DATA_WIDTH, 9, widest supported data field in bits (legal range 8..9).
- OVERSAMPLE, 16, oversample ticks per bit (even, ≥8).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- ov_tick_i  in  1  one-cycle pulse at OVERSAMPLE×baud
- rx_i  in  1  raw serial line, idle high
- data_bits_i  in  4  data field width, 5..MAX_DATA_WIDTH
- parity_mode_i  in  3  000 even, 001 odd, 010 none, 011 mark, 100 space; 101–111 treated as none
- stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
- data_o  out  MAX_DATA_WIDTH  received word, right-aligned, unused MSBs zero
- data_valid_o  out  1  one-cycle pulse, frame complete
- parity_err_o  out  1  qualifies data_valid_o
- frame_err_o  out  1  qualifies data_valid_o
- break_o  out  1  one-cycle pulse, break detected
- cfg_err_o  out  1  level; data_bits_i out of range at the last start detection
- busy_o  out  1  high from start detection until return to IDLE

Behaviour:
- Reset values:
  - All outputs 0, FSM in IDLE.
  - Both synchroniser flops reset to 1.
  - The armed flag resets to 0.
- Synchroniser and armed flag:
  - rx_i passes through a 2-FF synchroniser.
  - The armed flag sets on the first synchronised high.
  - No start bit is accepted while disarmed. This rejects a line held low through reset.
- Configuration latching:
  - data_bits_i, parity_mode_i and stop_bits_i are latched at start detection and held for the whole frame.
  - Mid-frame changes to these inputs have no effect.
  - If data_bits_i is below 5 or above MAX_DATA_WIDTH, use 8 and set cfg_err_o until the next start detection.
- Sampling:
  - A tick counter runs on ov_tick_i only.
  - Bit value = majority of the synchronised samples at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
  - The decision is made at tick OVERSAMPLE/2+1.
- FSM states:
  - IDLE: armed and synchronised line 0 on an ov tick → START, tick count 0, busy_o=1.
  - START: majority = 1 → IDLE (false start, no outputs). Majority = 0 → DATA.
  - DATA: shift in LSB first, one bit per OVERSAMPLE ticks. After data_bits bits → PARITY if parity is enabled, else STOP.
  - PARITY: compute the expected bit:
    - even: XOR of the data bits
    - odd: its inverse
    - mark: 1
    - space: 0
    - Mismatch sets the internal parity flag. → STOP.
  - STOP: sample the stop bit; a 0 sets the frame flag. With stop_bits=1, a second stop bit is sampled. → finish.
  - Finish, break case: all data bits 0, parity bit 0 (if present) and first stop bit 0.
    - Pulse break_o, no data_valid_o → BREAK_WAIT.
  - Finish, otherwise: in the cycle after the final decision tick, pulse data_valid_o with data_o, parity_err_o and frame_err_o valid.
    - data_o holds until the next valid.
    - The error flags are high only during the valid cycle.
    - If the frame error came from the first stop bit → BREAK_WAIT, else → IDLE.
  - BREAK_WAIT: stay until the synchronised line is 1 → IDLE.
- Simultaneous events:
  - A new start edge in the same cycle as the data_valid_o pulse is accepted. IDLE is re-entered combinationally on the next tick, so no start is lost.
  - ov_tick_i held high continuously behaves as a tick every cycle.
- Reset mid-frame: asynchronous return to IDLE, outputs cleared, partial data discarded, no valid pulse.

Test Plan:
- 8-bit, no parity, 1 stop, byte 0xA5 at OVERSAMPLE=16 → exactly one data_valid_o, data_o=0x0A5, both error flags 0, busy_o low one tick later.
- 5-bit, even parity, 2 stops, data 0x13 with parity bit 1 → valid with data_o=0x013, parity_err_o=0. Same frame with parity 0 → parity_err_o=1.
- 9-bit, odd parity, data 0x1FF, second stop bit 0 → valid with data_o=0x1FF, frame_err_o=1, then return to IDLE without BREAK_WAIT.
- Line low for 2 frame times in 8N1 → break_o pulses once, no data_valid_o. No new frame until the line goes high, then 0x3C is received correctly.
- Glitch: rx low for 4 ov ticks → returns to IDLE, no outputs. A 1-tick glitch at a sample point inside a data bit is outvoted by the majority.
- rst_i asserted mid-DATA with the line then held low → no outputs after reset, no start until the line goes high. data_bits_i=3 → cfg_err_o=1 and an 8-bit frame 0x81 is decoded.

Source files
------------

// File: rtl/uart_rx_frame_engine.sv
// UART receive framer: 2-FF synchroniser, armed flag, majority-vote sampling,
// per-frame data width (5..MAX_DATA_WIDTH), five parity modes, 1 or 2 stop
// bits and break detection. Frames are presented as a one-cycle valid pulse.
module uart_rx_frame_engine #(
    parameter int MAX_DATA_WIDTH = 9,
    parameter int OVERSAMPLE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ov_tick_i,
    input  logic                      rx_i,
    input  logic [3:0]                data_bits_i,
    input  logic [2:0]                parity_mode_i,
    input  logic                      stop_bits_i,
    output logic [MAX_DATA_WIDTH-1:0] data_o,
    output logic                      data_valid_o,
    output logic                      parity_err_o,
    output logic                      frame_err_o,
    output logic                      break_o,
    output logic                      cfg_err_o,
    output logic                      busy_o
);

    localparam int CW = $clog2(OVERSAMPLE);

    // Sample points inside one bit period; the vote is taken at T_DECIDE.
    localparam logic [CW-1:0] T_SAMPLE_A = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_SAMPLE_B = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_DECIDE   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] T_LAST     = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    MAX_BITS   = 4'(MAX_DATA_WIDTH);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
    localparam logic [2:0] S_PARITY     = 3'd3;
    localparam logic [2:0] S_STOP       = 3'd4;
    localparam logic [2:0] S_BREAK_WAIT = 3'd5;

    localparam logic [2:0] PAR_EVEN  = 3'b000;
    localparam logic [2:0] PAR_ODD   = 3'b001;
    localparam logic [2:0] PAR_MARK  = 3'b011;
    localparam logic [2:0] PAR_SPACE = 3'b100;

    logic                      sync_q1, sync_q2;
    logic [1:0]                fill_q;
    logic                      armed_q;
    logic [2:0]                state_q;
    logic [CW-1:0]             tick_cnt_q;
    logic                      smp_a_q, smp_b_q;
    logic [3:0]                bit_idx_q;
    logic [3:0]                dbits_q;
    logic [2:0]                pmode_q;
    logic                      stop2_q;
    logic [MAX_DATA_WIDTH-1:0] data_q;
    logic                      par_err_q, par_bit_q;
    logic                      frame_err_q, stop1_err_q, stop_idx_q;

    logic rx_s, maj, decide, par_en, exp_par, cfg_bad, start_det;
    logic last_data, final_stop, stop1_zero, frame_err_all, is_break;

    // Decode the latched frame configuration and the current bit vote.
    always_comb begin
        rx_s          = sync_q2;
        maj           = (smp_a_q & smp_b_q) | (smp_a_q & rx_s) | (smp_b_q & rx_s);
        decide        = ov_tick_i && (tick_cnt_q == T_DECIDE);
        par_en        = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD) ||
                        (pmode_q == PAR_MARK) || (pmode_q == PAR_SPACE);
        case (pmode_q)
            PAR_EVEN: exp_par = ^data_q;
            PAR_ODD:  exp_par = ~(^data_q);
            PAR_MARK: exp_par = 1'b1;
            default:  exp_par = 1'b0;
        endcase
        cfg_bad       = (data_bits_i < 4'd5) || (data_bits_i > MAX_BITS);
        start_det     = (state_q == S_IDLE) && armed_q && !rx_s && ov_tick_i;
        last_data     = (4'(bit_idx_q + 4'd1) == dbits_q);
        final_stop    = !stop2_q || stop_idx_q;
        stop1_zero    = stop_idx_q ? stop1_err_q : ~maj;
        frame_err_all = frame_err_q | ~maj;
        is_break      = (data_q == '0) && (!par_en || !par_bit_q) && stop1_zero;
    end

    assign busy_o = (state_q != S_IDLE);

    // Synchronise the line and arm once a genuine high has come through.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, so the two stages really are two stages.
            sync_q1 <= rx_i;
            sync_q2 <= sync_q1;
            // The synchroniser resets high; wait until its output reflects
            // rx_i before trusting a high, so a line held low through reset
            // never arms the receiver.
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && sync_q2)
                armed_q <= 1'b1;
        end
    end

    // Frame FSM: bit timing, vote decisions, shifting and result reporting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            smp_a_q      <= 1'b1;
            smp_b_q      <= 1'b1;
            bit_idx_q    <= '0;
            dbits_q      <= 4'd8;
            pmode_q      <= 3'b010;
            stop2_q      <= 1'b0;
            data_q       <= '0;
            par_err_q    <= 1'b0;
            par_bit_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            stop1_err_q  <= 1'b0;
            stop_idx_q   <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            cfg_err_o    <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;

            if (ov_tick_i && (state_q != S_IDLE) && (state_q != S_BREAK_WAIT)) begin
                tick_cnt_q <= (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + CW'(1);
                if (tick_cnt_q == T_SAMPLE_A) smp_a_q <= rx_s;
                if (tick_cnt_q == T_SAMPLE_B) smp_b_q <= rx_s;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_det) begin
                        state_q     <= S_START;
                        tick_cnt_q  <= '0;
                        dbits_q     <= cfg_bad ? 4'd8 : data_bits_i;
                        cfg_err_o   <= cfg_bad;
                        pmode_q     <= parity_mode_i;
                        stop2_q     <= stop_bits_i;
                        data_q      <= '0;
                        bit_idx_q   <= '0;
                        par_err_q   <= 1'b0;
                        par_bit_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                        stop1_err_q <= 1'b0;
                        stop_idx_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (decide)
                        state_q <= maj ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (decide) begin
                        data_q    <= data_q | (MAX_DATA_WIDTH'(maj) << bit_idx_q);
                        bit_idx_q <= bit_idx_q + 4'd1;
                        if (last_data)
                            state_q <= par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (decide) begin
                        par_bit_q <= maj;
                        par_err_q <= (maj != exp_par);
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (decide) begin
                        if (!final_stop) begin
                            stop_idx_q  <= 1'b1;
                            stop1_err_q <= ~maj;
                            frame_err_q <= ~maj;
                        end else if (is_break) begin
                            break_o <= 1'b1;
                            state_q <= S_BREAK_WAIT;
                        end else begin
                            data_valid_o <= 1'b1;
                            data_o       <= data_q;
                            parity_err_o <= par_err_q;
                            frame_err_o  <= frame_err_all;
                            state_q      <= stop1_zero ? S_BREAK_WAIT : S_IDLE;
                        end
                    end
                end
                S_BREAK_WAIT: begin
                    if (rx_s)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Scoreboard bench for uart_rx_frame_engine: directed frames push expected
// results; an independent monitor pops and compares on every valid/break.
module tb_uart_rx_frame_engine;

    localparam int MAXW = 9;
    localparam int OVS  = 16;
    localparam int DIV  = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            ov_tick_i = 1'b0;
    logic            rx_i = 1'b1;
    logic [3:0]      data_bits_i = 4'd8;
    logic [2:0]      parity_mode_i = 3'b010;
    logic            stop_bits_i = 1'b0;
    logic [MAXW-1:0] data_o;
    logic            data_valid_o, parity_err_o, frame_err_o, break_o, cfg_err_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit tick_cont = 1'b0;

    typedef struct {
        bit         is_break;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    uart_rx_frame_engine #(.MAX_DATA_WIDTH(MAXW), .OVERSAMPLE(OVS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ov_tick_i(ov_tick_i), .rx_i(rx_i),
        .data_bits_i(data_bits_i), .parity_mode_i(parity_mode_i), .stop_bits_i(stop_bits_i),
        .data_o(data_o), .data_valid_o(data_valid_o), .parity_err_o(parity_err_o),
        .frame_err_o(frame_err_o), .break_o(break_o), .cfg_err_o(cfg_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Oversample tick: one cycle in DIV, or held high in continuous mode.
    initial begin
        forever begin
            if (tick_cont) begin
                ov_tick_i = 1'b1;
                @(negedge clk_i);
            end else begin
                ov_tick_i = 1'b0;
                repeat (DIV - 1) @(negedge clk_i);
                ov_tick_i = 1'b1;
                @(negedge clk_i);
                ov_tick_i = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk_i); while (!ov_tick_i);
        @(negedge clk_i);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        rx_i = b;
        if (glitch) begin
            wait_ticks(OVS / 2);
            rx_i = ~b;
            wait_ticks(1);
            rx_i = b;
            wait_ticks(OVS / 2 - 1);
        end else begin
            wait_ticks(OVS);
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input bit has_par,
                              input logic pbit, input logic s1, input bit two_stop,
                              input logic s2, input int glitch_bit, input bit scramble);
        logic [3:0] sv_db;
        logic [2:0] sv_pm;
        logic       sv_sb;
        wait_tick();
        sv_db = data_bits_i;
        sv_pm = parity_mode_i;
        sv_sb = stop_bits_i;
        send_bit(1'b0, 1'b0);
        if (scramble) begin
            data_bits_i   = 4'd5;
            parity_mode_i = 3'b000;
            stop_bits_i   = 1'b1;
        end
        for (int i = 0; i < nbits; i++) send_bit(d[i], i == glitch_bit);
        if (has_par) send_bit(pbit, 1'b0);
        send_bit(s1, 1'b0);
        if (two_stop) send_bit(s2, 1'b0);
        if (scramble) begin
            data_bits_i   = sv_db;
            parity_mode_i = sv_pm;
            stop_bits_i   = sv_sb;
        end
        rx_i = 1'b1;
        wait_ticks(12);
    endtask

    task automatic expect_frame(input logic [8:0] d, input logic perr, input logic ferr,
                                input logic busy);
        exp_t e;
        e.is_break = 1'b0;
        e.data     = d;
        e.perr     = perr;
        e.ferr     = ferr;
        e.busy     = busy;
        sb.push_back(e);
    endtask

    task automatic expect_break();
        exp_t e;
        e.is_break = 1'b1;
        e.data     = '0;
        e.perr     = 1'b0;
        e.ferr     = 1'b0;
        e.busy     = 1'b1;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // Monitor: every valid or break pulse is matched against the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i && (data_valid_o || break_o)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: valid=%0b break=%0b data=0x%0h, expected none",
                         data_valid_o, break_o, data_o);
            end else begin
                mon_e = sb.pop_front();
                check("break_pulse", break_o, mon_e.is_break);
                check("valid_pulse", data_valid_o, !mon_e.is_break);
                if (!mon_e.is_break) begin
                    check("data", data_o, mon_e.data);
                    check("parity_err", parity_err_o, mon_e.perr);
                    check("frame_err", frame_err_o, mon_e.ferr);
                end
                check("busy_at_result", busy_o, mon_e.busy);
            end
        end
    end

    initial begin
        #600us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_data", data_o, 0);
        check("rst_flags", {data_valid_o, parity_err_o, frame_err_o, break_o, cfg_err_o}, 0);
        check("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        wait_ticks(4);

        // 8N1 0xA5 with mid-frame configuration changes that must be ignored.
        expect_frame(9'h0A5, 1'b0, 1'b0, 1'b0);
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b1);
        wait_drain("drain_a5", 2000);
        check("a5_busy_low", busy_o, 0);

        // 5E2 0x13: correct parity 1, then wrong parity 0.
        data_bits_i = 4'd5; parity_mode_i = 3'b000; stop_bits_i = 1'b1;
        expect_frame(9'h013, 1'b0, 1'b0, 1'b0);
        send_frame(9'h013, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        expect_frame(9'h013, 1'b1, 1'b0, 1'b0);
        send_frame(9'h013, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        wait_drain("drain_5e2", 2000);

        // 9O2 0x1FF with second stop bit low: frame error, back to IDLE.
        data_bits_i = 4'd9; parity_mode_i = 3'b001; stop_bits_i = 1'b1;
        expect_frame(9'h1FF, 1'b0, 1'b1, 1'b0);
        send_frame(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        wait_drain("drain_9o2", 2000);
        wait_ticks(20);
        check("9o2_idle", busy_o, 0);

        // 8N1 0x0F with first stop bit low: frame error, holds in BREAK_WAIT.
        data_bits_i = 4'd8; parity_mode_i = 3'b010; stop_bits_i = 1'b0;
        expect_frame(9'h00F, 1'b0, 1'b1, 1'b1);
        send_frame(9'h00F, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("drain_stop1", 2000);

        // Break: line low for two frame times, then a normal 0x3C.
        expect_break();
        wait_tick();
        rx_i = 1'b0;
        wait_ticks(20 * OVS);
        check("break_hold_busy", busy_o, 1);
        wait_drain("drain_break", 10);
        rx_i = 1'b1;
        wait_ticks(4);
        check("break_released", busy_o, 0);
        expect_frame(9'h03C, 1'b0, 1'b0, 1'b0);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("drain_3c", 2000);

        // False start: line low for 4 ticks only.
        wait_tick();
        rx_i = 1'b0;
        wait_ticks(4);
        rx_i = 1'b1;
        check("false_start_busy", busy_o, 1);
        wait_ticks(12);
        check("false_start_idle", busy_o, 0);

        // One-tick glitch at a sample point of data bit 2 is outvoted.
        expect_frame(9'h055, 1'b0, 1'b0, 1'b0);
        send_frame(9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        wait_drain("drain_glitch", 2000);

        // Continuous tick: 7M1 0x5A, then 6S1 0x2A with a wrong (1) space bit.
        tick_cont = 1'b1;
        data_bits_i = 4'd7; parity_mode_i = 3'b011; stop_bits_i = 1'b0;
        expect_frame(9'h05A, 1'b0, 1'b0, 1'b0);
        send_frame(9'h05A, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        data_bits_i = 4'd6; parity_mode_i = 3'b100;
        expect_frame(9'h02A, 1'b1, 1'b0, 1'b0);
        send_frame(9'h02A, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("drain_cont", 2000);
        tick_cont = 1'b0;

        // Reset in the middle of the data field with the line held low.
        data_bits_i = 4'd8; parity_mode_i = 3'b010; stop_bits_i = 1'b0;
        wait_tick();
        rx_i = 1'b0;
        wait_ticks(4 * OVS);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("midrst_data", data_o, 0);
        check("midrst_busy", busy_o, 0);
        rst_i = 1'b0;
        wait_ticks(3 * OVS);
        check("midrst_no_start", busy_o, 0);
        rx_i = 1'b1;
        wait_ticks(4);

        // Out-of-range width falls back to 8 bits and flags the config.
        data_bits_i = 4'd3;
        expect_frame(9'h081, 1'b0, 1'b0, 1'b0);
        send_frame(9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("drain_cfg", 2000);
        check("cfg_err_set", cfg_err_o, 1);
        data_bits_i = 4'd8;
        expect_frame(9'h07E, 1'b0, 1'b0, 1'b0);
        send_frame(9'h07E, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("drain_7e", 2000);
        check("cfg_err_clear", cfg_err_o, 0);

        wait_ticks(8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
